// File: rtl/exec_mem_pkg.sv
// Shared encodings for exec_mem_unit: MIPS opcode/funct codes, ALU operation,
// memory access size and branch condition enums.
package exec_mem_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef enum logic [4:0] {
    ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI
  } alu_op_t;

  typedef enum logic [1:0] { BYTE, HALF, WORD } mem_size_t;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ
  } br_cond_t;

endpackage

// File: rtl/exec_mem_unit_decoder.sv
// Instruction decoder: opcode/rt/funct fields -> datapath controls and ALU op.
// SUBWORD_MEM_EN enables lb/lh/lbu/lhu/sb/sh; without it they decode as nop.
module exec_mem_decoder (
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [5:0] funct,
  output logic       jump,
  output logic       jump_reg,
  output logic       link,
  output logic       reg_dst,
  output logic       reg_wr,
  output logic       mem_to_reg,
  output logic       mem_wr,
  output logic       ext_op,
  output logic       alu_src_imm,
  output logic       shamt_var,
  output logic       mem_signed,
  output exec_mem_pkg::mem_size_t mem_size,
  output exec_mem_pkg::br_cond_t  br_cond,
  output exec_mem_pkg::alu_op_t   alu_op
);
  import exec_mem_pkg::*;

  logic load, store, imm_alu;

  // Pure combinational decode; anything unrecognised falls through as a nop.
  always_comb begin
    jump = 1'b0; jump_reg = 1'b0; link = 1'b0; reg_dst = 1'b0; reg_wr = 1'b0;
    mem_to_reg = 1'b0; mem_wr = 1'b0; ext_op = 1'b0; alu_src_imm = 1'b0;
    shamt_var = 1'b0; mem_signed = 1'b0; mem_size = WORD; br_cond = BR_NONE;
    alu_op = ADD; load = 1'b0; store = 1'b0; imm_alu = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        reg_wr  = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_op = ADD;
          F_SUB, F_SUBU: alu_op = SUB;
          F_AND:  alu_op = AND;
          F_OR:   alu_op = OR;
          F_XOR:  alu_op = XOR;
          F_NOR:  alu_op = NOR;
          F_SLT:  alu_op = SLT;
          F_SLTU: alu_op = SLTU;
          F_SLL:  alu_op = SLL;
          F_SRL:  alu_op = SRL;
          F_SRA:  alu_op = SRA;
          F_SLLV: begin alu_op = SLL; shamt_var = 1'b1; end
          F_SRLV: begin alu_op = SRL; shamt_var = 1'b1; end
          F_SRAV: begin alu_op = SRA; shamt_var = 1'b1; end
          F_JR:   begin reg_dst = 1'b0; reg_wr = 1'b0; jump = 1'b1; jump_reg = 1'b1; end
          default: begin reg_dst = 1'b0; reg_wr = 1'b0; end
        endcase
      end
      OP_ADDIU: begin imm_alu = 1'b1; ext_op = 1'b1; alu_op = ADD;  end
      OP_SLTI:  begin imm_alu = 1'b1; ext_op = 1'b1; alu_op = SLT;  end
      OP_SLTIU: begin imm_alu = 1'b1; ext_op = 1'b1; alu_op = SLTU; end
      OP_ANDI:  begin imm_alu = 1'b1; alu_op = AND; end
      OP_ORI:   begin imm_alu = 1'b1; alu_op = OR;  end
      OP_XORI:  begin imm_alu = 1'b1; alu_op = XOR; end
      OP_LUI:   begin imm_alu = 1'b1; alu_op = LUI; end
      OP_LW:    begin load = 1'b1; mem_size = WORD; end
      OP_SW:    begin store = 1'b1; mem_size = WORD; end
`ifdef SUBWORD_MEM_EN
      OP_LB:    begin load = 1'b1; mem_size = BYTE; mem_signed = 1'b1; end
      OP_LBU:   begin load = 1'b1; mem_size = BYTE; end
      OP_LH:    begin load = 1'b1; mem_size = HALF; mem_signed = 1'b1; end
      OP_LHU:   begin load = 1'b1; mem_size = HALF; end
      OP_SB:    begin store = 1'b1; mem_size = BYTE; end
      OP_SH:    begin store = 1'b1; mem_size = HALF; end
`endif
      OP_BEQ:   begin br_cond = BR_EQ;  alu_op = SUB; ext_op = 1'b1; end
      OP_BNE:   begin br_cond = BR_NE;  alu_op = SUB; ext_op = 1'b1; end
      OP_BLEZ:  begin br_cond = BR_LEZ; alu_op = SUB; ext_op = 1'b1; end
      OP_BGTZ:  begin br_cond = BR_GTZ; alu_op = SUB; ext_op = 1'b1; end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          br_cond = BR_LTZ; ext_op = 1'b1;
        end else if (rt == RT_BGEZ) begin
          br_cond = BR_GEZ; ext_op = 1'b1;
        end
      end
      OP_J:     jump = 1'b1;
      OP_JAL:   begin jump = 1'b1; link = 1'b1; reg_wr = 1'b1; end
      default:  ;
    endcase
    // Immediate-operand ALU ops write rt; loads/stores address with bus_a + sext(imm).
    if (imm_alu) begin
      reg_wr = 1'b1; alu_src_imm = 1'b1;
    end
    if (load) begin
      reg_wr = 1'b1; mem_to_reg = 1'b1; ext_op = 1'b1; alu_src_imm = 1'b1;
    end
    if (store) begin
      mem_wr = 1'b1; ext_op = 1'b1; alu_src_imm = 1'b1;
    end
  end

endmodule

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: decoder + ALU + little-endian data memory for the single-cycle
// MIPS core. Optional sub-word loads/stores are enabled by SUBWORD_MEM_EN.
module exec_mem_unit #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic [31:0] bus_a,
  input  logic [31:0] bus_b,
  output logic        branch,
  output logic        jump,
  output logic        jump_reg,
  output logic        link,
  output logic        reg_dst,
  output logic        reg_wr,
  output logic        mem_to_reg,
  output logic        ext_op,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_rdata
);
  import exec_mem_pkg::*;

  localparam int AW = $clog2(DM_WORDS);

  logic        jump_dec, reg_wr_dec, mem_wr, alu_src_imm, shamt_var, mem_signed;
  mem_size_t   mem_size;
  br_cond_t    br_cond;
  alu_op_t     alu_op;
  logic [31:0] imm_ext, alu_b;
  logic signed [31:0] a_s, b_s;
  logic [4:0]  shamt;
  logic        br_take;
  logic [AW-1:0] idx;
  logic [31:0] mem_q [DM_WORDS];
  logic [31:0] rd_word, wr_word_d;
  logic        wr_en_d;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        unused_ins;

  exec_mem_decoder u_dec (
    .op(ins[31:26]), .rt(ins[20:16]), .funct(ins[5:0]),
    .jump(jump_dec), .jump_reg(jump_reg), .link(link), .reg_dst(reg_dst),
    .reg_wr(reg_wr_dec), .mem_to_reg(mem_to_reg), .mem_wr(mem_wr), .ext_op(ext_op),
    .alu_src_imm(alu_src_imm), .shamt_var(shamt_var), .mem_signed(mem_signed),
    .mem_size(mem_size), .br_cond(br_cond), .alu_op(alu_op)
  );

  // rs field is consumed by the register file outside this block.
  assign unused_ins = ^ins[25:21];

  assign imm_ext = ext_op ? {{16{ins[15]}}, ins[15:0]} : {16'h0000, ins[15:0]};
  assign alu_b   = alu_src_imm ? imm_ext : bus_b;
  assign a_s     = bus_a;
  assign b_s     = alu_b;
  assign shamt   = shamt_var ? bus_a[4:0] : ins[10:6];

  // ALU: computed for every instruction, including nops.
  always_comb begin
    case (alu_op)
      ADD:     alu_result = bus_a + alu_b;
      SUB:     alu_result = bus_a - alu_b;
      AND:     alu_result = bus_a & alu_b;
      OR:      alu_result = bus_a | alu_b;
      XOR:     alu_result = bus_a ^ alu_b;
      NOR:     alu_result = ~(bus_a | alu_b);
      SLT:     alu_result = {31'b0, a_s < b_s};
      SLTU:    alu_result = {31'b0, bus_a < alu_b};
      SLL:     alu_result = alu_b << shamt;
      SRL:     alu_result = alu_b >> shamt;
      SRA:     alu_result = b_s >>> shamt;
      LUI:     alu_result = {ins[15:0], 16'h0000};
      default: alu_result = bus_a + alu_b;
    endcase
  end

  assign zero = (alu_result == 32'h0);

  // Branch condition: signed compares against rs (and rt for beq/bne).
  always_comb begin
    case (br_cond)
      BR_EQ:   br_take = (bus_a == bus_b);
      BR_NE:   br_take = (bus_a != bus_b);
      BR_LEZ:  br_take = (a_s <= 0);
      BR_GTZ:  br_take = (a_s > 0);
      BR_LTZ:  br_take = (a_s < 0);
      BR_GEZ:  br_take = (a_s >= 0);
      default: br_take = 1'b0;
    endcase
  end

  assign branch = rst & br_take;
  assign jump   = rst & jump_dec;
  assign reg_wr = rst & reg_wr_dec;

  assign idx     = alu_result[AW+1:2];
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{alu_result[1:0], 3'b000} +: 8];
  assign rd_half = rd_word[{alu_result[1], 4'b0000} +: 16];

  // Load extraction and extension by access size.
  always_comb begin
    case (mem_size)
      BYTE:    mem_rdata = mem_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      HALF:    mem_rdata = mem_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: mem_rdata = rd_word;
    endcase
  end

  // Store merge: read-modify-write so sb/sh touch only their byte lanes.
  always_comb begin
    wr_en_d   = mem_wr & rst;
    wr_word_d = rd_word;
    case (mem_size)
      BYTE:    wr_word_d[{alu_result[1:0], 3'b000} +: 8] = bus_b[7:0];
      HALF:    wr_word_d[{alu_result[1], 4'b0000} +: 16] = bus_b[15:0];
      default: wr_word_d = bus_b;
    endcase
  end

  // Data memory: whole array cleared while in reset, otherwise one word per store.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (wr_en_d) begin
      mem_q[idx] <= wr_word_d;
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed + randomized bench for exec_mem_unit with a byte-array reference model.
module tb_exec_mem_unit;

  logic        clk, rst;
  logic [31:0] ins, bus_a, bus_b;
  logic        branch, jump, jump_reg, link, reg_dst, reg_wr, mem_to_reg, ext_op, zero;
  logic [31:0] alu_result, mem_rdata;

  int checks = 0;
  int failures = 0;

`ifdef SUBWORD_MEM_EN
  localparam bit SUBW = 1'b1;
`else
  localparam bit SUBW = 1'b0;
`endif

  exec_mem_unit #(.DM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .ins(ins), .bus_a(bus_a), .bus_b(bus_b),
    .branch(branch), .jump(jump), .jump_reg(jump_reg), .link(link),
    .reg_dst(reg_dst), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .ext_op(ext_op),
    .alu_result(alu_result), .zero(zero), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mbytes [4096];

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] rdata;
    logic chk_res, chk_ext, chk_dst, chk_rd;
    logic br, jmp, jr, lnk, dst, wr, m2r, ext;
    logic st;
    logic [2:0] st_bytes;
  } exp_t;

  function automatic logic [31:0] rtype(input int rs, rt, rd, sh, fn);
    logic [31:0] w;
    w = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    return w;
  endfunction

  function automatic logic [31:0] itype(input int op, rs, rt, input logic [15:0] imm);
    logic [31:0] w;
    w = {6'(op), 5'(rs), 5'(rt), imm};
    return w;
  endfunction

  function automatic logic [31:0] ld_word(input logic [31:0] adr);
    int b;
    b = int'({adr[11:2], 2'b00});
    return {mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]};
  endfunction

  // Reference: behaviour of each instruction computed directly from its meaning.
  function automatic exp_t model(input logic [31:0] i, a, b, input logic r);
    exp_t e;
    int op, fn, rt, sh, bb;
    logic [31:0] se, ze, adr;
    logic [15:0] h;
    e = '0;
    op = int'(i[31:26]); fn = int'(i[5:0]); rt = int'(i[20:16]); sh = int'(i[10:6]);
    se = {{16{i[15]}}, i[15:0]}; ze = {16'h0, i[15:0]}; adr = a + se;
    if (op == 0) begin
      e.chk_res = 1; e.wr = 1; e.dst = 1; e.chk_dst = 1;
      case (fn)
        32, 33: e.res = a + b;
        34, 35: e.res = a - b;
        36: e.res = a & b;
        37: e.res = a | b;
        38: e.res = a ^ b;
        39: e.res = ~(a | b);
        42: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        43: e.res = (a < b) ? 32'd1 : 32'd0;
        0:  e.res = b << sh;
        2:  e.res = b >> sh;
        3:  e.res = $signed(b) >>> sh;
        4:  e.res = b << a[4:0];
        6:  e.res = b >> a[4:0];
        7:  e.res = $signed(b) >>> a[4:0];
        8: begin e.chk_res = 0; e.wr = 0; e.dst = 0; e.chk_dst = 0; e.jmp = 1; e.jr = 1; end
        default: begin e.chk_res = 0; e.wr = 0; e.chk_dst = 0; e.dst = 0; end
      endcase
    end else if (op >= 9 && op <= 15) begin
      e.chk_res = 1; e.wr = 1; e.chk_dst = 1; e.chk_ext = 1; e.ext = (op <= 11);
      case (op)
        9:  e.res = a + se;
        10: e.res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        11: e.res = (a < se) ? 32'd1 : 32'd0;
        12: e.res = a & ze;
        13: e.res = a | ze;
        14: e.res = a ^ ze;
        default: e.res = {i[15:0], 16'h0};
      endcase
    end else if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37) begin
      e.chk_ext = 1;
      if (op == 35 || SUBW) begin
        e.chk_res = 1; e.res = adr; e.ext = 1; e.wr = 1; e.m2r = 1;
        e.chk_dst = 1; e.chk_rd = 1;
        bb = int'(adr[11:0]);
        h = {mbytes[int'({adr[11:1], 1'b1})], mbytes[int'({adr[11:1], 1'b0})]};
        case (op)
          32: e.rdata = {{24{mbytes[bb][7]}}, mbytes[bb]};
          36: e.rdata = {24'h0, mbytes[bb]};
          33: e.rdata = {{16{h[15]}}, h};
          37: e.rdata = {16'h0, h};
          default: e.rdata = ld_word(adr);
        endcase
      end
    end else if (op == 40 || op == 41 || op == 43) begin
      e.chk_ext = 1;
      if (op == 43 || SUBW) begin
        e.chk_res = 1; e.res = adr; e.ext = 1; e.st = 1;
        e.st_bytes = (op == 40) ? 3'd1 : (op == 41) ? 3'd2 : 3'd4;
      end
    end else begin
      case (op)
        4: e.br = (a == b);
        5: e.br = (a != b);
        6: e.br = ($signed(a) <= 0);
        7: e.br = ($signed(a) > 0);
        1: e.br = (rt == 0) ? ($signed(a) < 0) : (rt == 1) ? ($signed(a) >= 0) : 1'b0;
        2: e.jmp = 1;
        3: begin e.jmp = 1; e.lnk = 1; e.wr = 1; end
        default: ;
      endcase
    end
    if (!r) begin e.wr = 0; e.br = 0; e.jmp = 0; e.st = 0; end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one instruction for a cycle, compare all defined outputs, then
  // update the reference memory for the edge that follows.
  task automatic step(input logic r, input logic [31:0] i, a, b);
    exp_t e;
    logic [31:0] adr;
    int base;
    @(posedge clk); #1;
    rst = r; ins = i; bus_a = a; bus_b = b;
    @(negedge clk);
    e = model(i, a, b, r);
    chk("branch", {31'b0, branch}, {31'b0, e.br});
    chk("jump", {31'b0, jump}, {31'b0, e.jmp});
    chk("jump_reg", {31'b0, jump_reg}, {31'b0, e.jr});
    chk("link", {31'b0, link}, {31'b0, e.lnk});
    chk("reg_wr", {31'b0, reg_wr}, {31'b0, e.wr});
    chk("mem_to_reg", {31'b0, mem_to_reg}, {31'b0, e.m2r});
    if (e.chk_dst) chk("reg_dst", {31'b0, reg_dst}, {31'b0, e.dst});
    if (e.chk_ext) chk("ext_op", {31'b0, ext_op}, {31'b0, e.ext});
    if (e.chk_res) begin
      chk("alu_result", alu_result, e.res);
      chk("zero", {31'b0, zero}, {31'b0, (e.res == 32'h0)});
    end
    if (e.chk_rd) chk("mem_rdata", mem_rdata, e.rdata);
    if (!r) begin
      for (int k = 0; k < 4096; k++) mbytes[k] = 8'h00;
    end else if (e.st) begin
      adr = a + {{16{i[15]}}, i[15:0]};
      base = (e.st_bytes == 3'd4) ? int'({adr[11:2], 2'b00}) :
             (e.st_bytes == 3'd2) ? int'({adr[11:1], 1'b0}) : int'(adr[11:0]);
      for (int k = 0; k < int'(e.st_bytes); k++) mbytes[base + k] = b[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 9));
      1: return 32'h8000_0000 + 32'($urandom_range(0, 2));
      2: return 32'h7FFF_FFFF - 32'($urandom_range(0, 2));
      3: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] fns [17];
  logic [5:0] iops [22];

  initial begin
    logic [31:0] i, a, b, lw_t0;
    logic [15:0] imm;
    int op;
    for (int k = 0; k < 4096; k++) mbytes[k] = 8'h00;
    fns  = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd32, 6'd33, 6'd34, 6'd35,
             6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd8};
    iops = '{6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd4, 6'd5, 6'd6, 6'd7,
             6'd1, 6'd2, 6'd3, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43};
    rst = 1'b0; ins = 32'h0; bus_a = 32'h0; bus_b = 32'h0;
    lw_t0 = itype(35, 0, 8, 16'h0000);

    // Reset: two clocks low, including a store that must not happen.
    step(1'b0, lw_t0, 32'h0, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_reg_wr", {31'b0, reg_wr}, 32'h0);
    step(1'b0, itype(43, 0, 9, 16'h0000), 32'h0, 32'hFFFF_FFFF);
    step(1'b1, lw_t0, 32'h0, 32'h0);
    chk("post_rst_rdata", mem_rdata, 32'h0);

    step(1'b1, rtype(9, 10, 11, 0, 33), 32'h7FFF_FFFF, 32'h1);
    chk("addu_res", alu_result, 32'h8000_0000);
    chk("addu_zero", {31'b0, zero}, 32'h0);
    step(1'b1, rtype(9, 10, 11, 0, 35), 32'd5, 32'd5);
    chk("subu_zero", {31'b0, zero}, 32'h1);
    step(1'b1, rtype(0, 10, 11, 4, 3), 32'h0, 32'hF000_0000);
    chk("sra_res", alu_result, 32'hFF00_0000);
    step(1'b1, rtype(9, 10, 11, 0, 42), 32'hFFFF_FFFF, 32'h1);
    chk("slt_res", alu_result, 32'h1);
    step(1'b1, rtype(9, 10, 11, 0, 43), 32'hFFFF_FFFF, 32'h1);
    chk("sltu_res", alu_result, 32'h0);

    step(1'b1, itype(43, 0, 9, 16'h0010), 32'h0, 32'hDEAD_BEEF);
    step(1'b1, itype(35, 0, 8, 16'h0010), 32'h0, 32'h0);
    chk("lw_after_sw", mem_rdata, 32'hDEAD_BEEF);
`ifdef SUBWORD_MEM_EN
    step(1'b1, itype(32, 0, 8, 16'h0013), 32'h0, 32'h0);
    chk("lb_0x13", mem_rdata, 32'hFFFF_FFDE);
    step(1'b1, itype(37, 0, 8, 16'h0010), 32'h0, 32'h0);
    chk("lhu_0x10", mem_rdata, 32'h0000_BEEF);
`else
    step(1'b1, itype(32, 0, 8, 16'h0013), 32'h0, 32'h0);
    chk("lb_nop_reg_wr", {31'b0, reg_wr}, 32'h0);
`endif

    step(1'b1, 32'h0721_0010, 32'h0, 32'h0);
    chk("bgez_taken", {31'b0, branch}, 32'h1);
    step(1'b1, 32'h0721_0010, 32'h8000_0000, 32'h0);
    chk("bgez_not", {31'b0, branch}, 32'h0);
    step(1'b1, itype(5, 1, 2, 16'h0004), 32'd7, 32'd7);
    chk("bne_eq", {31'b0, branch}, 32'h0);
    step(1'b1, {6'd3, 26'h0000100}, 32'h0, 32'h0);
    chk("jal_flags", {29'b0, jump, link, reg_wr}, 32'h7);
    step(1'b1, rtype(31, 0, 0, 0, 8), 32'h0000_4000, 32'h0);
    chk("jr_jump_reg", {31'b0, jump_reg}, 32'h1);
    step(1'b1, itype(13, 1, 2, 16'h8000), 32'h1234_5678, 32'h0);
    chk("ori_ext", {31'b0, ext_op}, 32'h0);
    chk("ori_res", alu_result, 32'h1234_D678);
    step(1'b1, itype(15, 0, 2, 16'h1234), 32'h0, 32'h0);
    chk("lui_res", alu_result, 32'h1234_0000);

    // Randomized mix against the reference model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        i = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), int'(fns[$urandom_range(0, 16)]));
        a = rval(); b = rval();
      end else begin
        op = int'(iops[$urandom_range(0, 21)]);
        imm = 16'($urandom);
        a = rval(); b = ($urandom_range(0, 2) == 0) ? a : rval();
        if (op >= 32) begin
          a = 32'h200 + 32'($urandom_range(0, 15) * 4);
          imm = 16'($urandom_range(0, 32)) - 16'd16;
          b = $urandom;
        end
        i = itype(op, $urandom_range(0, 31), (op == 1) ? $urandom_range(0, 2) : $urandom_range(0, 31), imm);
      end
      step(1'b1, i, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
